// File: rtl/register_bank.sv
// DEPTH x WIDTH register bank with one write/modify port, two async read ports and registered carry/zero flags.
// Writes take effect one mclk after issue when mclk_en=1. There is no backpressure. Optional forwarding is enabled by REGBANK_BYPASS_EN.
module register_bank #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int RESET_VALUE = 0
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              mclk_en,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_load_data,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [WIDTH-1:0]  o_data_a,
  output logic [WIDTH-1:0]  o_data_b,
  output logic              o_carry,
  output logic              o_zero
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_COPY = 3'b111;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             carry_q;
  logic             zero_q;

  logic [WIDTH-1:0] raw_a;
  logic [WIDTH-1:0] raw_b;
  logic [WIDTH-1:0] cur_r;
  logic             wr_valid;
  logic [WIDTH-1:0] r_d;
  logic             carry_d;
  logic             wr_en;

  // Decode by matching each legal index, so out-of-range addresses fall through to zero.
  always_comb begin
    raw_a    = '0;
    raw_b    = '0;
    cur_r    = '0;
    wr_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd_addr_a == ADDR_W'(i)) raw_a = mem_q[i];
      if (i_rd_addr_b == ADDR_W'(i)) raw_b = mem_q[i];
      if (i_wr_addr == ADDR_W'(i)) begin
        cur_r    = mem_q[i];
        wr_valid = 1'b1;
      end
    end
  end

  always_comb begin
    r_d     = cur_r;
    carry_d = 1'b0;
    case (i_op)
      OP_LOAD: r_d = i_load_data;
      OP_INC: begin
        r_d     = cur_r + WIDTH'(1);
        carry_d = (cur_r == '1);
      end
      OP_DEC: begin
        r_d     = cur_r - WIDTH'(1);
        carry_d = (cur_r == '0);
      end
      OP_SHL: begin
        r_d     = {cur_r[WIDTH-2:0], 1'b0};
        carry_d = cur_r[WIDTH-1];
      end
      OP_SHR: begin
        r_d     = {1'b0, cur_r[WIDTH-1:1]};
        carry_d = cur_r[0];
      end
      OP_CLR:  r_d = '0;
      OP_COPY: r_d = raw_a;
      default: r_d = cur_r;
    endcase
  end

  assign wr_en = mclk_en && (i_op != OP_HOLD) && wr_valid;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= WIDTH'(RESET_VALUE);
      carry_q <= 1'b0;
      zero_q  <= (RESET_VALUE == 0);
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_wr_addr == ADDR_W'(i)) mem_q[i] <= r_d;
      end
      carry_q <= carry_d;
      zero_q  <= (r_d == '0);
    end
  end

`ifdef REGBANK_BYPASS_EN
  // The COPY source uses raw_a rather than o_data_a, so forwarding cannot loop back into r_d.
  assign o_data_a = (wr_en && (i_rd_addr_a == i_wr_addr)) ? r_d : raw_a;
  assign o_data_b = (wr_en && (i_rd_addr_b == i_wr_addr)) ? r_d : raw_b;
`else
  assign o_data_a = raw_a;
  assign o_data_b = raw_b;
`endif

  assign o_carry = carry_q;
  assign o_zero  = zero_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: a DEPTH=4 and a DEPTH=3 instance share stimulus and are checked against a behavioural model.
module tb_register_bank;

  logic       mclk;
  logic       rst_n;
  logic       mclk_en;
  logic [2:0] i_op;
  logic [1:0] i_wr_addr;
  logic [7:0] i_load_data;
  logic [1:0] i_rd_addr_a;
  logic [1:0] i_rd_addr_b;
  logic [7:0] da4, db4, da3, db3;
  logic       c4, z4, c3, z3;

  int checks = 0;
  int errors = 0;

`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  register_bank #(.WIDTH(8), .DEPTH(4)) dut4 (
    .mclk(mclk), .rst_n(rst_n), .mclk_en(mclk_en), .i_op(i_op),
    .i_wr_addr(i_wr_addr), .i_load_data(i_load_data),
    .i_rd_addr_a(i_rd_addr_a), .i_rd_addr_b(i_rd_addr_b),
    .o_data_a(da4), .o_data_b(db4), .o_carry(c4), .o_zero(z4)
  );

  register_bank #(.WIDTH(8), .DEPTH(3)) dut3 (
    .mclk(mclk), .rst_n(rst_n), .mclk_en(mclk_en), .i_op(i_op),
    .i_wr_addr(i_wr_addr), .i_load_data(i_load_data),
    .i_rd_addr_a(i_rd_addr_a), .i_rd_addr_b(i_rd_addr_b),
    .o_data_a(da3), .o_data_b(db3), .o_carry(c3), .o_zero(z3)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Model: index 0 is the DEPTH=4 instance, index 1 the DEPTH=3 instance.
  logic [7:0] m  [2][4];
  logic       mc [2];
  logic       mz [2];

  function automatic int dep(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic [7:0] mread(input int d, input logic [1:0] a);
    if (int'(a) < dep(d)) return m[d][a];
    return 8'h00;
  endfunction

  function automatic bit wval(input int d);
    return mclk_en && (i_op != 3'd0) && (int'(i_wr_addr) < dep(d));
  endfunction

  function automatic void mnext(input int d, output logic [7:0] nr, output logic nc);
    logic [7:0] r;
    int         v;
    r  = mread(d, i_wr_addr);
    v  = int'(r);
    nr = r;
    nc = 1'b0;
    case (i_op)
      3'd1: nr = i_load_data;
      3'd2: begin nr = 8'((v + 1) % 256);       nc = (v == 255); end
      3'd3: begin nr = 8'((v + 255) % 256);     nc = (v == 0);   end
      3'd4: begin nr = 8'((v * 2) % 256);       nc = (v >= 128); end
      3'd5: begin nr = 8'(v / 2);               nc = (v % 2 == 1); end
      3'd6: nr = 8'h00;
      3'd7: nr = mread(d, i_rd_addr_a);
      default: nr = r;
    endcase
  endfunction

  function automatic logic [7:0] mexp(input int d, input logic [1:0] a);
    logic [7:0] nr;
    logic       nc;
    if (BYP && wval(d) && (a == i_wr_addr)) begin
      mnext(d, nr, nc);
      return nr;
    end
    return mread(d, a);
  endfunction

  always @(posedge mclk or negedge rst_n) begin : model_upd
    logic [7:0] nr;
    logic       nc;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) m[d][i] = 8'h00;
        mc[d] = 1'b0;
        mz[d] = 1'b1;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (wval(d)) begin
          mnext(d, nr, nc);
          m[d][i_wr_addr] = nr;
          mc[d] = nc;
          mz[d] = (nr == 8'h00);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge mclk) begin
    chk("cmp d4 data_a", da4, mexp(0, i_rd_addr_a));
    chk("cmp d4 data_b", db4, mexp(0, i_rd_addr_b));
    chk("cmp d4 carry", {7'd0, c4}, {7'd0, mc[0]});
    chk("cmp d4 zero", {7'd0, z4}, {7'd0, mz[0]});
    chk("cmp d3 data_a", da3, mexp(1, i_rd_addr_a));
    chk("cmp d3 data_b", db3, mexp(1, i_rd_addr_b));
    chk("cmp d3 carry", {7'd0, c3}, {7'd0, mc[1]});
    chk("cmp d3 zero", {7'd0, z3}, {7'd0, mz[1]});
  end

  task automatic op(input logic en, input logic [2:0] o, input logic [1:0] wa,
                    input logic [7:0] ld, input logic [1:0] ra, input logic [1:0] rb);
    mclk_en = en; i_op = o; i_wr_addr = wa; i_load_data = ld;
    i_rd_addr_a = ra; i_rd_addr_b = rb;
    @(posedge mclk);
    #1;
    mclk_en = 1'b0; i_op = 3'd0;
  endtask

  task automatic rd(input logic [1:0] ra, input logic [1:0] rb);
    i_rd_addr_a = ra; i_rd_addr_b = rb;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mclk_en = 1'b0; i_op = 3'd0; i_wr_addr = 2'd0;
    i_load_data = 8'h00; i_rd_addr_a = 2'd0; i_rd_addr_b = 2'd0;
    repeat (3) @(posedge mclk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      rd(2'(i), 2'(3 - i));
      chk("reset entry a", da4, 8'h00);
      chk("reset entry b", db4, 8'h00);
    end
    chk("reset carry", {7'd0, c4}, 8'h00);
    chk("reset zero", {7'd0, z4}, 8'h01);

    op(1'b0, 3'd1, 2'd2, 8'h5A, 2'd2, 2'd2); rd(2'd2, 2'd2);
    chk("gated load", da4, 8'h00);
    op(1'b1, 3'd1, 2'd2, 8'h5A, 2'd2, 2'd2); rd(2'd2, 2'd2);
    chk("load e2", da4, 8'h5A);
    chk("load e2 d3", da3, 8'h5A);
    chk("load carry", {7'd0, c4}, 8'h00);
    chk("load zero", {7'd0, z4}, 8'h00);

    op(1'b1, 3'd1, 2'd1, 8'hFF, 2'd1, 2'd1);
    op(1'b1, 3'd2, 2'd1, 8'h00, 2'd1, 2'd1); rd(2'd1, 2'd1);
    chk("inc wrap", da4, 8'h00);
    chk("inc carry", {7'd0, c4}, 8'h01);
    chk("inc zero", {7'd0, z4}, 8'h01);
    op(1'b1, 3'd3, 2'd1, 8'h00, 2'd1, 2'd1); rd(2'd1, 2'd1);
    chk("dec wrap", da4, 8'hFF);
    chk("dec borrow", {7'd0, c4}, 8'h01);
    chk("dec zero", {7'd0, z4}, 8'h00);

    op(1'b1, 3'd1, 2'd0, 8'h81, 2'd0, 2'd0);
    op(1'b1, 3'd4, 2'd0, 8'h00, 2'd0, 2'd0); rd(2'd0, 2'd0);
    chk("shl", da4, 8'h02);
    chk("shl carry", {7'd0, c4}, 8'h01);
    op(1'b1, 3'd5, 2'd0, 8'h00, 2'd0, 2'd0); rd(2'd0, 2'd0);
    chk("shr1", da4, 8'h01);
    chk("shr1 carry", {7'd0, c4}, 8'h00);
    op(1'b1, 3'd5, 2'd0, 8'h00, 2'd0, 2'd0); rd(2'd0, 2'd0);
    chk("shr2", da4, 8'h00);
    chk("shr2 carry", {7'd0, c4}, 8'h01);
    chk("shr2 zero", {7'd0, z4}, 8'h01);

    op(1'b1, 3'd1, 2'd3, 8'h3C, 2'd3, 2'd3); rd(2'd3, 2'd3);
    chk("load e3", da4, 8'h3C);
    chk("d3 invalid read", da3, 8'h00);
    chk("d3 invalid wr carry", {7'd0, c3}, 8'h01);
    chk("d3 invalid wr zero", {7'd0, z3}, 8'h01);
    op(1'b1, 3'd7, 2'd0, 8'h00, 2'd3, 2'd0); rd(2'd0, 2'd3);
    chk("copy dst", da4, 8'h3C);
    chk("copy src kept", db4, 8'h3C);
    chk("d3 copy invalid src", da3, 8'h00);
    chk("d3 copy zero", {7'd0, z3}, 8'h01);
    op(1'b1, 3'd6, 2'd3, 8'h00, 2'd3, 2'd0); rd(2'd3, 2'd0);
    chk("clr", da4, 8'h00);
    chk("clr zero", {7'd0, z4}, 8'h01);
    chk("clr other", db4, 8'h3C);
    op(1'b1, 3'd0, 2'd0, 8'h11, 2'd3, 2'd0); rd(2'd3, 2'd0);
    chk("hold entry", db4, 8'h3C);
    chk("hold zero", {7'd0, z4}, 8'h01);
    chk("hold carry", {7'd0, c4}, 8'h00);

    mclk_en = 1'b1; i_op = 3'd1; i_wr_addr = 2'd1; i_load_data = 8'h77;
    i_rd_addr_a = 2'd1; i_rd_addr_b = 2'd2;
    #1;
    chk("bypass same cycle", da4, BYP ? 8'h77 : 8'hFF);
    chk("bypass other port", db4, 8'h5A);
    @(posedge mclk); #1;
    mclk_en = 1'b0; i_op = 3'd0; #1;
    chk("bypass next cycle", da4, 8'h77);

    mclk_en = 1'b1; i_op = 3'd1; i_wr_addr = 2'd3; i_load_data = 8'h99;
    i_rd_addr_a = 2'd3; i_rd_addr_b = 2'd3;
    #1;
    chk("d3 invalid no fwd", da3, 8'h00);
    chk("d4 e3 fwd", da4, BYP ? 8'h99 : 8'h00);
    @(posedge mclk); #1;
    mclk_en = 1'b0; i_op = 3'd0; #1;
    chk("d3 invalid still 0", db3, 8'h00);

    mclk_en = 1'b1; i_op = 3'd2; i_wr_addr = 2'd1; i_rd_addr_a = 2'd1; i_rd_addr_b = 2'd3;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst data", da4, 8'h00);
    chk("async rst e3", db4, 8'h00);
    chk("async rst carry", {7'd0, c4}, 8'h00);
    chk("async rst zero", {7'd0, z4}, 8'h01);
    @(posedge mclk); #1;
    rst_n = 1'b1; mclk_en = 1'b0; i_op = 3'd0;

    op(1'b1, 3'd1, 2'd2, 8'h10, 2'd2, 2'd1); rd(2'd2, 2'd1);
    chk("post rst load", da4, 8'h10);
    chk("post rst other", db4, 8'h00);

    repeat (2) @(posedge mclk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
